fb_frame_forward_m: RTL and testbench

FB_FRAME_FORWARD_M -- requirements
Module: fb_frame_forward_m

---
 rtl/fb_frame_forward_m_pkg.sv | 27 ++
 rtl/fb_frame_forward_m_fifo.sv | 50 +++++
 rtl/fb_frame_forward_m.sv | 99 +++++++++
 tb/tb_fb_frame_forward_m.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_frame_forward_m_pkg.sv
// Shared definitions for the frame-forward stage: FSM state encoding,
// default widths and the per-state input-acceptance rule.
package fb_frame_forward_m_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PAY   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fwd_state_e;

  // Upstream is only ever ready while reading the header or buffering payload.
  function automatic logic state_accepts_input(input fwd_state_e state,
                                               input logic       fifo_full);
    case (state)
      ST_HDR:  return 1'b1;
      ST_PAY:  return !fifo_full;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fb_frame_forward_m_fifo.sv
// Small synchronous FIFO decoupling payload acceptance from the leaf interface.
// The head is visible the cycle after a push into an empty buffer.
module fb_fwd_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so equal indices disambiguate full/empty.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Stale storage is masked so an empty buffer always presents zero.
  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fb_frame_forward_m.sv
// Frame forwarder: consumes a word-count header, forwards that many payload
// words through a small buffer and pulses ap_done once the buffer has drained.
module fb_frame_forward_m
  import fb_frame_forward_m_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [DATA_W-1:0] Input_1_V_TDATA,
  input  logic              Input_1_V_TVALID,
  output logic              Input_1_V_TREADY,
  output logic [DATA_W-1:0] Output_1_V_TDATA,
  output logic              Output_1_V_TVALID,
  input  logic              Output_1_V_TREADY
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  fwd_state_e       state_reg;
  fwd_state_e       state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             in_xfer;
  logic             push;

  assign Input_1_V_TREADY = state_accepts_input(state_reg, fifo_full);
  assign in_xfer          = Input_1_V_TVALID && Input_1_V_TREADY;
  assign ap_idle          = (state_reg == ST_IDLE);
  assign ap_done          = (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ap_start) state_next = ST_HDR;
      end
      ST_HDR: begin
        // The header only loads the counter; it is never forwarded.
        if (in_xfer) begin
          count_next = Input_1_V_TDATA[CNT_W-1:0];
          state_next = (Input_1_V_TDATA[CNT_W-1:0] != '0) ? ST_PAY : ST_DONE;
        end
      end
      ST_PAY: begin
        if (in_xfer) begin
          push       = 1'b1;
          count_next = count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  fb_fwd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (Input_1_V_TDATA),
    .pop       (Output_1_V_TREADY),
    .head      (Output_1_V_TDATA),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign Output_1_V_TVALID = !fifo_empty;

endmodule

// File: tb/tb_fb_frame_forward_m.sv
// Scoreboard bench for fb_frame_forward_m: accepted payload words are queued as
// expectations and a negedge monitor pops them against the output stream.
module tb_fb_frame_forward_m;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_acc_cyc = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit          lat_check = 1'b1;
  bit          have_hold = 1'b0;
  logic [31:0] hold_data = '0;

  fb_frame_forward_m dut (
    .clk               (clk),
    .reset             (reset),
    .ap_start          (ap_start),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done),
    .Input_1_V_TDATA   (in_data),
    .Input_1_V_TVALID  (in_valid),
    .Input_1_V_TREADY  (in_ready),
    .Output_1_V_TDATA  (out_data),
    .Output_1_V_TVALID (out_valid),
    .Output_1_V_TREADY (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: output ordering, latency, hold stability and ap_done placement.
  always @(negedge clk) begin
    if (reset) begin
      have_hold = 1'b0;
    end else begin
      if (out_valid) begin
        if (have_hold) chk("hold_stable", out_data, hold_data);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            if (lat_check) chk("out_latency", cyc, e.cyc + 1);
          end
          have_hold = 1'b0;
        end else begin
          have_hold = 1'b1;
          hold_data = out_data;
        end
      end else begin
        have_hold = 1'b0;
      end
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_drain", (exp_q.size() == 0) && !out_valid, 1);
      end
    end
  end

  // Offer one word until accepted; payload words become expectations on transfer.
  task automatic send_word(input logic [31:0] d, input bit is_payload, input int vprob);
    int  waited = 0;
    bit  taken = 1'b0;
    while (!taken) begin
      in_valid = ($urandom_range(99) < vprob);
      in_data  = d;
      @(negedge clk);
      if (in_valid && in_ready) begin
        taken = 1'b1;
        last_acc_cyc = cyc;
        if (is_payload) exp_q.push_back('{data: d, cyc: cyc});
      end
      @(posedge clk);
      #1;
      waited++;
      if (!taken && waited > 2000) begin
        chk("input_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_header(input int n, input bit drop_start);
    logic [31:0] hdr;
    hdr = ($urandom() << 16) | 32'(n);
    ap_start = 1'b1;
    send_word(hdr, 1'b0, 100);
    if (drop_start) ap_start = 1'b0;
  endtask

  task automatic send_payload(input int n, input int vprob);
    for (int i = 0; i < n; i++) send_word($urandom(), 1'b1, vprob);
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, done_cnt, target);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic set_mode(input int mode);
    ready_mode = mode;
    lat_check  = (mode == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_idle"}, ap_idle, 1);
    chk({nm, "_done"}, ap_done, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    int n;
    int mode;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Three words, always-ready sink.
    set_mode(0);
    target = done_cnt + 1;
    send_header(3, 1'b1);
    send_payload(3, 100);
    wait_done(target, "frame3_done");
    @(negedge clk);
    chk("frame3_idle", ap_idle, 1);
    $display("frame len=3 complete, done_cnt=%0d", done_cnt);

    // Empty frame: no output, quick completion.
    target = done_cnt + 1;
    send_header(0, 1'b1);
    wait_done(target, "hdr0_done");
    chk("hdr0_done_latency", (done_cyc - last_acc_cyc >= 1) && (done_cyc - last_acc_cyc <= 2), 1);
    $display("frame len=0 complete, latency=%0d", done_cyc - last_acc_cyc);

    // Stalled sink: buffer fills at depth 4 and backpressures.
    set_mode(2);
    target = done_cnt + 1;
    send_header(8, 1'b1);
    send_payload(4, 100);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      @(negedge clk);
      chk("full_backpressure", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_mode = 0;
    send_payload(4, 100);
    wait_done(target, "frame8_done");
    $display("frame len=8 stalled complete, done_cnt=%0d", done_cnt);

    // Long frame with random handshakes on both sides.
    set_mode(1);
    target = done_cnt + 1;
    send_header(100, 1'b1);
    send_payload(100, 60);
    wait_done(target, "frame100_done");
    $display("frame len=100 random complete, done_cnt=%0d", done_cnt);

    for (int k = 0; k < 6; k++) begin
      n    = $urandom_range(1, 20);
      mode = $urandom_range(0, 1);
      set_mode(mode);
      target = done_cnt + 1;
      send_header(n, 1'b1);
      send_payload(n, $urandom_range(30, 100));
      wait_done(target, "rand_frame_done");
      $display("frame len=%0d mode=%0d complete, done_cnt=%0d", n, mode, done_cnt);
    end

    // Reset in the middle of a frame aborts it silently.
    set_mode(0);
    target = done_cnt;
    send_header(5, 1'b1);
    send_payload(2, 100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt, target);
    $display("frame len=5 aborted by reset, done_cnt=%0d", done_cnt);

    target = done_cnt + 1;
    send_header(4, 1'b1);
    send_payload(4, 100);
    wait_done(target, "post_reset_done");
    $display("frame len=4 after reset complete, done_cnt=%0d", done_cnt);

    // ap_start held high: two frames back to back.
    target = done_cnt + 2;
    send_header(3, 1'b0);
    send_payload(3, 100);
    send_header(5, 1'b0);
    send_payload(5, 100);
    wait_done(target, "b2b_done");
    ap_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done_exact", done_cnt, target);
    $display("back-to-back frames len=3,5 complete, done_cnt=%0d", done_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
